// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 block-chaining controller.
// Holds block width, FSM state encoding and chaining mode encodings.
package sm4_pkg;

   localparam int SM4_BLK_W = 128;

   localparam logic MODE_ECB = 1'b0;
   localparam logic MODE_CBC = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_e;

endpackage

// File: rtl/sm4_chain_xor.sv
// Chain register and ECB/CBC XOR selection around the SM4 core.
// Pre-core XOR applies to CBC encrypt, post-core XOR to CBC decrypt.
module sm4_chain_xor
   import sm4_pkg::*;
#(
   parameter int DATA_W = SM4_BLK_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_iv,
   input  logic [DATA_W-1:0] iv_in,
   input  logic              mode,
   input  logic              decrypt,
   input  logic              capture,
   input  logic [DATA_W-1:0] in_blk,
   input  logic [DATA_W-1:0] held_blk,
   input  logic [DATA_W-1:0] result_in,
   output logic [DATA_W-1:0] core_in_out,
   output logic [DATA_W-1:0] result_out
);

   logic [DATA_W-1:0] chain_q;
   logic [DATA_W-1:0] chain_d;

   // XOR selection and next chain value
   always_comb begin
      core_in_out = in_blk;
      result_out  = result_in;
      chain_d     = chain_q;
      if (mode == MODE_CBC && !decrypt) begin
         core_in_out = in_blk ^ chain_q;
      end
      if (mode == MODE_CBC && decrypt) begin
         result_out = result_in ^ chain_q;
      end
      if (load_iv) begin
         chain_d = iv_in;
      end else if (capture && mode == MODE_CBC) begin
         chain_d = decrypt ? held_blk : result_in;
      end
   end

   // Chain register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

endmodule

// File: rtl/sm4_mode_ctrl.sv
// SM4 block-chaining controller: stream in, one core op per block, stream out.
// Optional block counter enabled by defining SM4_MODE_BLKCNT_EN.
module sm4_mode_ctrl
   import sm4_pkg::*;
#(
   parameter int DATA_W = SM4_BLK_W
`ifdef SM4_MODE_BLKCNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_in,
   input  logic [DATA_W-1:0] iv_in,
   input  logic              cbc_in,
   input  logic              decrypt_in,
   output logic              busy_out,
   input  logic              s_valid_in,
   output logic              s_ready_out,
   input  logic [DATA_W-1:0] s_data_in,
   input  logic              s_last_in,
   output logic              m_valid_out,
   input  logic              m_ready_in,
   output logic [DATA_W-1:0] m_data_out,
   output logic              m_last_out,
   output logic              core_encdec_enable_out,
   output logic              core_encdec_sel_out,
   output logic [DATA_W-1:0] core_data_out,
   input  logic              core_ready_in,
   input  logic [DATA_W-1:0] core_result_in,
   input  logic              core_key_ready_in
`ifdef SM4_MODE_BLKCNT_EN
   ,
   output logic [CNT_W-1:0]  blk_count_out
`endif
);

   state_e            state_q, state_d;
   logic              active_q, active_d;
   logic              cbc_q, cbc_d;
   logic              dec_q, dec_d;
   logic [DATA_W-1:0] blk_q, blk_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] cdata_q, cdata_d;
   logic              en_q, en_d;
   logic              arm_q, arm_d;
   logic              mvalid_q, mvalid_d;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic              mlast_q, mlast_d;

   logic              start_ok;
   logic              hs_in;
   logic              hs_out;
   logic              capture;
   logic [DATA_W-1:0] core_in;
   logic [DATA_W-1:0] res;

   assign s_ready_out = (state_q == IDLE) & active_q
                      & core_key_ready_in & core_ready_in;

   assign busy_out               = active_q;
   assign m_valid_out            = mvalid_q;
   assign m_data_out             = mdata_q;
   assign m_last_out             = mlast_q;
   assign core_encdec_enable_out = en_q;
   assign core_encdec_sel_out    = dec_q;
   assign core_data_out          = cdata_q;

   sm4_chain_xor #(
      .DATA_W (DATA_W)
   ) u_chain (
      .clk         (clk),
      .reset_n     (reset_n),
      .load_iv     (start_ok),
      .iv_in       (iv_in),
      .mode        (cbc_q),
      .decrypt     (dec_q),
      .capture     (capture),
      .in_blk      (s_data_in),
      .held_blk    (blk_q),
      .result_in   (core_result_in),
      .core_in_out (core_in),
      .result_out  (res)
   );

   // Handshake qualifiers
   always_comb begin
      start_ok = start_in & (state_q == IDLE) & ~active_q;
      hs_in    = s_valid_in & s_ready_out;
      hs_out   = mvalid_q & m_ready_in;
      // The first WAIT cycle sees the core's ready from before it took enable.
      capture  = (state_q == WAIT) & arm_q & core_ready_in;
   end

   // FSM next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      cbc_d    = cbc_q;
      dec_d    = dec_q;
      blk_d    = blk_q;
      last_d   = last_q;
      cdata_d  = cdata_q;
      en_d     = 1'b0;
      arm_d    = arm_q;
      mvalid_d = mvalid_q;
      mdata_d  = mdata_q;
      mlast_d  = mlast_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               active_d = 1'b1;
               cbc_d    = cbc_in;
               dec_d    = decrypt_in;
            end else if (hs_in) begin
               blk_d   = s_data_in;
               last_d  = s_last_in;
               cdata_d = core_in;
               en_d    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            arm_d   = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            arm_d = 1'b1;
            if (capture) begin
               mdata_d  = res;
               mlast_d  = last_q;
               mvalid_d = 1'b1;
               state_d  = OUT;
            end
         end
         OUT: begin
            if (hs_out) begin
               mvalid_d = 1'b0;
               state_d  = IDLE;
               if (mlast_q) begin
                  active_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         active_q <= 1'b0;
         cbc_q    <= MODE_ECB;
         dec_q    <= 1'b0;
         blk_q    <= '0;
         last_q   <= 1'b0;
         cdata_q  <= '0;
         en_q     <= 1'b0;
         arm_q    <= 1'b0;
         mvalid_q <= 1'b0;
         mdata_q  <= '0;
         mlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         cbc_q    <= cbc_d;
         dec_q    <= dec_d;
         blk_q    <= blk_d;
         last_q   <= last_d;
         cdata_q  <= cdata_d;
         en_q     <= en_d;
         arm_q    <= arm_d;
         mvalid_q <= mvalid_d;
         mdata_q  <= mdata_d;
         mlast_q  <= mlast_d;
      end
   end

`ifdef SM4_MODE_BLKCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign blk_count_out = cnt_q;

   // Saturating count of result handshakes, cleared per message
   always_comb begin
      cnt_d = cnt_q;
      if (start_ok) begin
         cnt_d = '0;
      end else if (hs_out && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Block counter register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_sm4_mode_ctrl.sv
// Bench for sm4_mode_ctrl with a stand-in invertible cipher core.
// Expected blocks come from a message-level ECB/CBC reference model.
module tb_sm4_mode_ctrl;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start_in;
   logic [127:0] iv_in;
   logic         cbc_in;
   logic         decrypt_in;
   logic         busy_out;
   logic         s_valid_in;
   logic         s_ready_out;
   logic [127:0] s_data_in;
   logic         s_last_in;
   logic         m_valid_out;
   logic         m_ready_in;
   logic [127:0] m_data_out;
   logic         m_last_out;
   logic         core_en;
   logic         core_sel;
   logic [127:0] core_data;
   logic         core_ready = 1'b1;
   logic [127:0] core_result = '0;
   logic         key_rdy;
`ifdef SM4_MODE_BLKCNT_EN
   logic [31:0]  blk_count_out;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] P0 = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] C0 = 128'h681EDF34D206965E86B3E94F536E4246;
   logic [127:0] key;

   always #5 clk = ~clk;

   sm4_mode_ctrl dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .start_in               (start_in),
      .iv_in                  (iv_in),
      .cbc_in                 (cbc_in),
      .decrypt_in             (decrypt_in),
      .busy_out               (busy_out),
      .s_valid_in             (s_valid_in),
      .s_ready_out            (s_ready_out),
      .s_data_in              (s_data_in),
      .s_last_in              (s_last_in),
      .m_valid_out            (m_valid_out),
      .m_ready_in             (m_ready_in),
      .m_data_out             (m_data_out),
      .m_last_out             (m_last_out),
      .core_encdec_enable_out (core_en),
      .core_encdec_sel_out    (core_sel),
      .core_data_out          (core_data),
      .core_ready_in          (core_ready),
      .core_result_in         (core_result),
      .core_key_ready_in      (key_rdy)
`ifdef SM4_MODE_BLKCNT_EN
      ,
      .blk_count_out          (blk_count_out)
`endif
   );

   // Stand-in cipher: a keyed rotation, chosen so enc(P0) == C0.
   function automatic logic [127:0] rotl13(input logic [127:0] x);
      return {x[114:0], x[127:115]};
   endfunction

   function automatic logic [127:0] rotr13(input logic [127:0] x);
      return {x[12:0], x[127:13]};
   endfunction

   function automatic logic [127:0] enc(input logic [127:0] x);
      return rotl13(x) ^ key;
   endfunction

   function automatic logic [127:0] decf(input logic [127:0] y);
      return rotr13(y ^ key);
   endfunction

   // Core model: ready drops on the enable edge, result after 1..5 cycles
   int           en_pulses = 0;
   int           bad_en = 0;
   int           core_cnt = 0;
   logic         core_sel_l = 1'b0;
   logic [127:0] core_in_l = '0;

   always @(posedge clk) begin
      if (!reset_n) begin
         core_ready <= 1'b1;
         core_cnt   <= 0;
      end else if (core_en) begin
         en_pulses  <= en_pulses + 1;
         if (!core_ready) bad_en <= bad_en + 1;
         core_ready <= 1'b0;
         core_cnt   <= int'($urandom_range(1, 5));
         core_sel_l <= core_sel;
         core_in_l  <= core_data;
      end else if (!core_ready) begin
         if (core_cnt <= 1) begin
            core_ready  <= 1'b1;
            core_result <= core_sel_l ? decf(core_in_l) : enc(core_in_l);
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   logic [127:0] blk   [8];
   logic [127:0] exp_o [8];
   logic [127:0] exp_ci[8];

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Message-level ECB/CBC model over blk[0..n-1]
   task automatic model(input bit cbc, input bit dec,
                        input logic [127:0] iv, input int n);
      logic [127:0] prev;
      prev = iv;
      for (int i = 0; i < n; i++) begin
         if (!cbc) begin
            exp_ci[i] = blk[i];
            exp_o[i]  = dec ? decf(blk[i]) : enc(blk[i]);
         end else if (!dec) begin
            exp_ci[i] = blk[i] ^ prev;
            exp_o[i]  = enc(exp_ci[i]);
            prev      = exp_o[i];
         end else begin
            exp_ci[i] = blk[i];
            exp_o[i]  = decf(blk[i]) ^ prev;
            prev      = blk[i];
         end
      end
   endtask

   task automatic start_msg(input bit cbc, input bit dec,
                            input logic [127:0] iv);
      start_in   = 1'b1;
      cbc_in     = cbc;
      decrypt_in = dec;
      iv_in      = iv;
      @(negedge clk);
      start_in = 1'b0;
      check("busy_after_start", 128'(busy_out), 128'(1));
   endtask

   task automatic send(input int i, input bit last);
      int cyc;
      cyc        = 0;
      s_valid_in = 1'b1;
      s_data_in  = blk[i];
      s_last_in  = last;
      #1;
      while (!s_ready_out && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("s_hs_timeout", 128'(cyc < 200), 128'(1));
      @(negedge clk);
      s_valid_in = 1'b0;
      check("enable_issue", 128'(core_en), 128'(1));
      check("core_in", core_data, exp_ci[i]);
   endtask

   task automatic recv(input int i, input bit last, input bit bp);
      int cyc;
      logic [127:0] held;
      cyc = 0;
      while (!m_valid_out && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("m_valid_timeout", 128'(cyc < 200), 128'(1));
      if (bp) begin
         held = m_data_out;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_data_stable", m_data_out, held);
            check("bp_s_ready_low", 128'(s_ready_out), 128'(0));
            check("bp_valid_held", 128'(m_valid_out), 128'(1));
         end
      end
      check("m_data", m_data_out, exp_o[i]);
      check("m_last", 128'(m_last_out), 128'(last));
      m_ready_in = 1'b1;
      @(negedge clk);
      m_ready_in = 1'b0;
   endtask

   task automatic run_msg(input bit cbc, input bit dec,
                          input logic [127:0] iv, input int n,
                          input int bp_idx, input bit poke_start);
      int p0;
      model(cbc, dec, iv, n);
      start_msg(cbc, dec, iv);
      p0 = en_pulses;
      for (int i = 0; i < n; i++) begin
         send(i, i == n - 1);
         recv(i, i == n - 1, i == bp_idx);
         if (poke_start && i == 0 && n > 1) begin
            start_in   = 1'b1;
            iv_in      = {$urandom, $urandom, $urandom, $urandom};
            cbc_in     = ~cbc;
            decrypt_in = ~dec;
            @(negedge clk);
            start_in = 1'b0;
         end
      end
      check("busy_after_last", 128'(busy_out), 128'(0));
      check("enable_pulses", 128'(en_pulses - p0), 128'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ct0, ct1, iv;
      int p0, n;
      bit cbc, dec;

      key        = rotl13(P0) ^ C0;
      reset_n    = 1'b0;
      start_in   = 1'b0;
      iv_in      = '0;
      cbc_in     = 1'b0;
      decrypt_in = 1'b0;
      s_valid_in = 1'b0;
      s_data_in  = '0;
      s_last_in  = 1'b0;
      m_ready_in = 1'b0;
      key_rdy    = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_ctrl", 128'({busy_out, s_ready_out, m_valid_out,
                              m_last_out, core_en, core_sel}), 128'(0));
      check("rst_m_data", m_data_out, '0);
      check("rst_core_data", core_data, '0);
`ifdef SM4_MODE_BLKCNT_EN
      check("rst_blk_count", 128'(blk_count_out), 128'(0));
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // ECB encrypt of the reference block
      blk[0] = P0;
      run_msg(1'b0, 1'b0, '0, 1, -1, 1'b0);
      check("ecb_vector", exp_o[0], C0);

      // CBC encrypt, IV 0, then a zero block; poke start mid-message
      blk[0] = P0;
      blk[1] = '0;
      run_msg(1'b1, 1'b0, '0, 2, -1, 1'b1);
      ct0 = exp_o[0];
      ct1 = exp_o[1];

      // CBC decrypt of those ciphertexts, with backpressure on block 1
      blk[0] = ct0;
      blk[1] = ct1;
      run_msg(1'b1, 1'b1, '0, 2, 1, 1'b0);
      check("cbc_dec_p0", exp_o[0], P0);

      // Key not ready: stall at s_ready_out, then accept next cycle
      blk[0] = {$urandom, $urandom, $urandom, $urandom};
      model(1'b0, 1'b0, '0, 1);
      start_msg(1'b0, 1'b0, '0);
      key_rdy    = 1'b0;
      s_valid_in = 1'b1;
      s_data_in  = blk[0];
      s_last_in  = 1'b1;
      p0         = en_pulses;
      repeat (6) begin
         @(negedge clk);
         check("key_stall_ready", 128'(s_ready_out), 128'(0));
      end
      check("key_stall_pulses", 128'(en_pulses - p0), 128'(0));
      key_rdy = 1'b1;
      #1;
      check("key_raise_ready", 128'(s_ready_out), 128'(1));
      @(negedge clk);
      s_valid_in = 1'b0;
      check("key_raise_enable", 128'(core_en), 128'(1));
      recv(0, 1'b1, 1'b0);
      check("key_busy_done", 128'(busy_out), 128'(0));

      // Randomized messages
      for (int m = 0; m < 8; m++) begin
         cbc = 1'($urandom);
         dec = 1'($urandom);
         n   = int'($urandom_range(1, 4));
         iv  = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < n; i++) begin
            blk[i] = {$urandom, $urandom, $urandom, $urandom};
         end
         run_msg(cbc, dec, iv, n, int'($urandom_range(0, 5)), 1'b1);
      end

      // Reset during WAIT, then a clean 5-block message
      blk[0] = P0;
      start_msg(1'b1, 1'b0, '0);
      s_valid_in = 1'b1;
      s_data_in  = P0;
      s_last_in  = 1'b0;
      #1;
      @(negedge clk);
      s_valid_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_ctrl", 128'({busy_out, s_ready_out, m_valid_out,
                                 m_last_out, core_en, core_sel}), 128'(0));
      check("midrst_m_data", m_data_out, '0);
      check("midrst_core_data", core_data, '0);
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         blk[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      run_msg(1'b1, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
              5, 2, 1'b0);
`ifdef SM4_MODE_BLKCNT_EN
      check("blk_count", 128'(blk_count_out), 128'(5));
`endif
      check("enable_while_core_busy", 128'(bad_en), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sm4_mode_ctrl.md
Name: sm4_mode_ctrl

Overview:
- Block-chaining controller between a streaming data source and the SM4 core (sm4_top).
- Accepts 128-bit blocks over a valid/ready stream and drives the core's enable, select and data inputs.
- Consumes the core's result, applies ECB or CBC chaining, and emits result blocks over a second valid/ready stream.
- Key expansion stays in sm4_top. This block only gates traffic on the core's key-ready status.

Parameters:
- DATA_W, 128, block width; only 128 is supported.
- CNT_W, 32, block-counter width (used only with SM4_MODE_BLKCNT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start_in  in  1  begin message; latches iv_in, cbc_in, decrypt_in.
- iv_in  in  128  CBC initialisation vector.
- cbc_in  in  1  0 = ECB, 1 = CBC.
- decrypt_in  in  1  0 = encrypt, 1 = decrypt.
- busy_out  out  1  message in progress.
- s_valid_in  in  1  input block valid.
- s_ready_out  out  1  input block accepted when s_valid_in & s_ready_out.
- s_data_in  in  128  input block.
- s_last_in  in  1  final block of message.
- m_valid_out  out  1  result block valid.
- m_ready_in  in  1  downstream ready.
- m_data_out  out  128  result block.
- m_last_out  out  1  final result of message.
- core_encdec_enable_out  out  1  one-cycle start pulse to core.
- core_encdec_sel_out  out  1  core direction; equals latched decrypt.
- core_data_out  out  128  core input block.
- core_ready_in  in  1  core ready_out (level).
- core_result_in  in  128  core result_out.
- core_key_ready_in  in  1  core key_exp_ready_out.

Behaviour:
- Reset: all outputs 0, state IDLE, chain register 0, msg_active 0.
- State IDLE:
  - start_in latches IV into the chain register, plus mode and direction, and sets msg_active. busy_out = msg_active.
  - start_in is ignored outside IDLE and while msg_active is set.
- Input acceptance:
  - s_ready_out = (state == IDLE) & msg_active & core_key_ready_in & core_ready_in. This is combinational from registered state.
  - On handshake, store the block and s_last_in, then go to ISSUE.
- State ISSUE (1 cycle):
  - core_encdec_enable_out = 1.
  - core_data_out is registered and stable from ISSUE until the result is captured:
    - CBC encrypt: block XOR chain.
    - CBC decrypt and ECB: block unchanged.
  - Next state WAIT.
- State WAIT:
  - The first WAIT cycle ignores core_ready_in, because the core drops ready on the edge that samples enable.
  - After that, core_ready_in = 1 captures the result:
    - ECB: result.
    - CBC encrypt: result; chain <= result.
    - CBC decrypt: result XOR chain; chain <= stored input block.
  - Next state OUT.
- State OUT:
  - m_valid_out = 1. m_data_out and m_last_out are held stable until m_ready_in.
  - On handshake go to IDLE. If m_last_out was set, clear msg_active.
- Back-to-back: throughput is one block per (core latency + 3) cycles. There is no overlap; the core is single-issue.
- core_key_ready_in falling mid-block does not abort. The current block completes, and new blocks stall at s_ready_out.
- ECB ignores the chain register and iv_in.
- Reset asserted in any state returns to IDLE next edge and drops any in-flight block. The core is reset by the same reset_n.

Optional Feature:
- SM4_MODE_BLKCNT_EN defined:
  - Adds output blk_count_out [CNT_W-1:0], counting result handshakes.
  - Cleared by reset and by accepted start_in.
  - Saturates at all-ones.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sm4_pkg holds:
  - SM4_BLK_W = 128.
  - State enum values IDLE / ISSUE / WAIT / OUT.
  - Mode encodings MODE_ECB = 0, MODE_CBC = 1.
- One natural sub-module: sm4_chain_xor, which holds the chain register and encrypt/decrypt XOR selection.
- The FSM stays in sm4_mode_ctrl.

Test Plan:
- ECB encrypt:
  - Key and block 0123456789ABCDEFFEDCBA9876543210, single block with last -> m_data_out = 681EDF34D206965E86B3E94F536E4246.
  - m_last_out = 1; busy_out falls after the handshake.
- CBC encrypt, IV = 0, same key and block -> first output 681EDF34D206965E86B3E94F536E4246.
  - Second block 0 -> core_data_out = 681EDF34D206965E86B3E94F536E4246.
  - Output equals the reference model.
- CBC decrypt of the two ciphertexts from the previous scenario, IV = 0 -> outputs 0123456789ABCDEFFEDCBA9876543210 then all-zero.
- Backpressure:
  - Hold m_ready_in = 0 for 10 cycles -> m_data_out stable, s_ready_out = 0 throughout, exactly one core_encdec_enable_out pulse per block.
- Key not ready:
  - core_key_ready_in = 0 with s_valid_in = 1 -> no handshake and no enable pulse.
  - Raise it -> block accepted the next cycle.
- Reset mid-WAIT -> all outputs 0 the next cycle, busy_out = 0, and a start_in of 5 blocks then completes normally.
  - With SM4_MODE_BLKCNT_EN defined, blk_count_out = 5.
